// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: RAM status type and the instruction/data/RAM bus bundle of the arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [1:0]  gnt;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, gnt
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, gnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction and data ports, data priority with starvation cap
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic        CLK,
  input logic        RST,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  state_t     state, next;
  logic [2:0] starve_cnt;
  logic       dreq, icomp, dcomp, done;
  assign dreq  = bus.dREN | bus.dWEN;
  assign done  = bus.ramstate == ACCESS || bus.ramstate == ERROR;
  // a completion needs the owner to still be requesting
  assign icomp = state == IGRANT && bus.ramstate == ACCESS && bus.iREN;
  assign dcomp = state == DGRANT && bus.ramstate == ACCESS && dreq;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= next;
  always_ff @(posedge CLK or posedge RST)
    if (RST) starve_cnt <= '0;
    else starve_cnt <= (!bus.iREN || icomp) ? 3'd0 :
                       (dcomp && starve_cnt < SMAX) ? starve_cnt + 3'd1 : starve_cnt;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = (dreq && starve_cnt < SMAX) ? DGRANT : bus.iREN ? IGRANT : IDLE;
      IGRANT:  next = (!bus.iREN || done) ? IDLE : IGRANT;
      DGRANT:  next = (!dreq || done) ? IDLE : DGRANT;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bus.gnt      = state == IGRANT ? 2'b01 : state == DGRANT ? 2'b10 : 2'b00;
    bus.ramaddr  = state == IGRANT ? bus.iaddr : state == DGRANT ? bus.daddr : '0;
    bus.ramstore = state == DGRANT ? bus.dstore : '0;
    bus.ramWEN   = state == DGRANT && bus.dWEN;
    bus.ramREN   = state == IGRANT || (state == DGRANT && bus.dREN && !bus.dWEN);
    bus.iwait    = bus.iREN && !icomp;
    bus.dwait    = dreq && !dcomp;
    bus.iload    = icomp ? bus.ramload : '0;
    bus.dload    = dcomp ? bus.ramload : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a completion scoreboard for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic CLK = 0;
  logic RST = 1;
  always #5 CLK = ~CLK;
  mem_arbiter_if b();
  mem_arbiter #(.STARVE_MAX(4)) dut (.CLK(CLK), .RST(RST), .bus(b));
  typedef struct {logic kind; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push(logic k, logic [31:0] d);
    sb.push_back(exp_t'{kind: k, data: d});
  endtask
  task automatic pop(logic k, logic [31:0] d);
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_kind", 32'(k), 32'(e.kind));
      chk(k ? "dload" : "iload", d, e.data);
    end
  endtask
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask
  task automatic smp();
    @(negedge CLK);
    #1;
  endtask
  always @(negedge CLK)
    if (!RST) begin
      if (b.iREN && !b.iwait) pop(1'b0, b.iload);
      if ((b.dREN || b.dWEN) && !b.dwait) pop(1'b1, b.dload);
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    b.iREN = 0; b.dREN = 0; b.dWEN = 0; b.iaddr = 0; b.daddr = 0;
    b.dstore = 0; b.ramload = 0; b.ramstate = FREE;
    #2;
    chk("rst_gnt", 32'(b.gnt), 0);
    chk("rst_en", 32'({b.ramREN, b.ramWEN}), 0);
    chk("rst_addr", b.ramaddr, 0);
    b.iREN = 1; b.iaddr = 32'h44;
    #1;
    chk("rst_iwait", 32'(b.iwait), 1);
    chk("rst_gnt_req", 32'(b.gnt), 0);
    b.iREN = 0;
    nxt();
    RST = 0;
    // instruction read, two BUSY cycles then ACCESS, with data-side noise
    nxt(); b.iREN = 1; b.iaddr = 32'h40; b.ramstate = BUSY; push(1'b0, 32'hDEADBEEF);
    smp(); chk("t1_idle_gnt", 32'(b.gnt), 0); chk("t1_idle_iwait", 32'(b.iwait), 1);
    nxt(); b.dWEN = 1; b.daddr = 32'h999; b.dstore = 32'h5;
    smp();
    chk("t1_gnt", 32'(b.gnt), 32'h1); chk("t1_ren", 32'(b.ramREN), 1);
    chk("t1_wen", 32'(b.ramWEN), 0); chk("t1_addr", b.ramaddr, 32'h40);
    chk("t1_store", b.ramstore, 0); chk("t1_iwait", 32'(b.iwait), 1); chk("t1_iload0", b.iload, 0);
    nxt(); b.dWEN = 0; smp(); chk("t1_busy2", 32'(b.gnt), 32'h1);
    nxt(); b.ramstate = ACCESS; b.ramload = 32'hDEADBEEF;
    smp(); chk("t1_done_iwait", 32'(b.iwait), 0);
    nxt(); b.iREN = 0; b.ramstate = FREE;
    smp(); chk("t1_back_idle", 32'(b.gnt), 0); chk("t1_iload_clr", b.iload, 0);
    // simultaneous requests: data write first, instruction afterwards
    nxt(); b.iREN = 1; b.dREN = 1; b.dWEN = 1; b.daddr = 32'h100; b.dstore = 32'h1234;
    b.iaddr = 32'h80; b.ramstate = BUSY; push(1'b1, 32'h55); push(1'b0, 32'h77);
    smp(); chk("t2_idle", 32'(b.gnt), 0);
    nxt(); smp();
    chk("t2_gnt", 32'(b.gnt), 32'h2); chk("t2_wen", 32'(b.ramWEN), 1);
    chk("t2_ren", 32'(b.ramREN), 0); chk("t2_addr", b.ramaddr, 32'h100);
    chk("t2_store", b.ramstore, 32'h1234); chk("t2_dwait", 32'(b.dwait), 1);
    nxt(); b.ramstate = ACCESS; b.ramload = 32'h55; smp(); chk("t2_dwait_lo", 32'(b.dwait), 0);
    nxt(); b.dREN = 0; b.dWEN = 0; b.ramstate = BUSY; smp(); chk("t2_mid_idle", 32'(b.gnt), 0);
    nxt(); smp(); chk("t2_igrant", 32'(b.gnt), 32'h1); chk("t2_iaddr", b.ramaddr, 32'h80);
    nxt(); b.ramstate = ACCESS; b.ramload = 32'h77; smp(); chk("t2_iwait_lo", 32'(b.iwait), 0);
    nxt(); b.iREN = 0; b.ramstate = FREE; smp();
    // ERROR retry, then owner drop with no completion
    nxt(); b.dREN = 1; b.daddr = 32'h300; smp();
    nxt(); b.ramstate = ERROR; smp();
    chk("t4_gnt", 32'(b.gnt), 32'h2); chk("t4_dwait", 32'(b.dwait), 1); chk("t4_dload", b.dload, 0);
    nxt(); b.ramstate = FREE; smp(); chk("t4_idle", 32'(b.gnt), 0);
    nxt(); smp(); chk("t4_regrant", 32'(b.gnt), 32'h2); chk("t4_ren", 32'(b.ramREN), 1);
    nxt(); b.ramstate = ACCESS; b.ramload = 32'h99; push(1'b1, 32'h99); smp();
    chk("t4_dwait_lo", 32'(b.dwait), 0);
    nxt(); b.ramstate = BUSY; smp(); chk("t4_idle2", 32'(b.gnt), 0);
    nxt(); smp(); chk("t4_grant3", 32'(b.gnt), 32'h2);
    nxt(); b.dREN = 0; smp(); chk("t4_drop_gnt", 32'(b.gnt), 32'h2); chk("t4_drop_dwait", 32'(b.dwait), 0);
    nxt(); smp(); chk("t4_drop_idle", 32'(b.gnt), 0);
    // starvation cap: four data completions then one instruction
    nxt(); b.iREN = 1; b.dREN = 1; b.iaddr = 32'h10; b.daddr = 32'h20; b.ramload = 32'hA5A5;
    b.ramstate = BUSY;
    for (int i = 0; i < 4; i++) push(1'b1, 32'hA5A5);
    push(1'b0, 32'hA5A5);
    for (int i = 0; i < 3; i++) push(1'b1, 32'hA5A5);
    for (int k = 0; k < 100 && sb.size() > 0; k++) begin
      nxt(); b.ramstate = k[0] ? ACCESS : BUSY; smp();
    end
    chk("t3_drain", 32'(sb.size()), 0);
    // reset with starvation counter nonzero must restart the 4-data budget
    b.ramstate = BUSY; RST = 1; #1;
    chk("t3_rst_gnt", 32'(b.gnt), 0); chk("t3_rst_en", 32'({b.ramREN, b.ramWEN}), 0);
    chk("t3_rst_addr", b.ramaddr, 0); chk("t3_rst_dload", b.dload, 0);
    chk("t3_rst_waits", 32'({b.iwait, b.dwait}), 32'h3);
    nxt(); nxt(); RST = 0;
    for (int i = 0; i < 4; i++) push(1'b1, 32'hA5A5);
    push(1'b0, 32'hA5A5);
    for (int k = 0; k < 100 && sb.size() > 0; k++) begin
      nxt(); b.ramstate = k[0] ? ACCESS : BUSY; smp();
    end
    chk("t3b_drain", 32'(sb.size()), 0);
    // reset pulsed mid-IGRANT
    nxt(); b.iREN = 0; b.dREN = 0; b.ramstate = FREE;
    nxt(); b.iREN = 1; b.iaddr = 32'h200; b.ramstate = BUSY; smp();
    nxt(); smp(); chk("t5_gnt", 32'(b.gnt), 32'h1);
    #1 RST = 1; #1;
    chk("t5_rst_gnt", 32'(b.gnt), 0); chk("t5_rst_ren", 32'(b.ramREN), 0);
    chk("t5_rst_addr", b.ramaddr, 0); chk("t5_rst_iload", b.iload, 0);
    chk("t5_rst_iwait", 32'(b.iwait), 1);
    nxt(); smp(); chk("t5_hold", 32'(b.gnt), 0);
    RST = 0;
    nxt(); smp(); chk("t5_resume", 32'(b.gnt), 32'h1);
    push(1'b0, 32'hCAFE);
    nxt(); b.ramstate = ACCESS; b.ramload = 32'hCAFE; smp();
    nxt(); b.iREN = 0; b.ramstate = FREE; smp();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while an instruction request waits; legal range 1-7.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port iREN  input  1  instruction read request.
REQ-005 SHALL have port iaddr  input  32  instruction address (word_t).
REQ-006 SHALL have port dREN  input  1  data read request.
REQ-007 SHALL have port dWEN  input  1  data write request.
REQ-008 SHALL have port daddr  input  32  data address.
REQ-009 SHALL have port dstore  input  32  data write value.
REQ-010 SHALL have port ramload  input  32  RAM read data.
REQ-011 SHALL have port ramstate  input  ramstate_t  RAM status FREE/BUSY/ACCESS/ERROR.
REQ-012 SHALL have port iwait  output  1  instruction stall; low for exactly the completing cycle.
REQ-013 SHALL have port dwait  output  1  data stall; low for exactly the completing cycle.
REQ-014 SHALL have port iload  output  32  instruction read data.
REQ-015 SHALL have port dload  output  32  data read data.
REQ-016 SHALL have port ramREN, ramWEN  output  1 each  RAM enables.
REQ-017 SHALL have port ramaddr, ramstore  output  32 each  RAM address / write data.
REQ-018 SHALL have port gnt  output  2  current grant: 00 none, 01 instr, 10 data.

Function
REQ-019 SHALL implement registered FSM states IDLE, IGRANT, DGRANT; RAM outputs decoded combinationally from current state only.
REQ-020 IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0, gnt=00.
REQ-021 IDLE transitions: data request (dREN|dWEN) and starve_cnt<STARVE_MAX -> DGRANT; else iREN -> IGRANT; else stay.
REQ-022 IDLE with both requests and starve_cnt==STARVE_MAX SHALL go to IGRANT.
REQ-023 DGRANT: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins over simultaneous dREN); else ramREN=dREN.
REQ-024 IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-025 Arbitration latency SHALL be one cycle: request seen in IDLE at edge N drives RAM from edge N onward.
REQ-026 In granted state with ramstate==ACCESS: owner's wait=0 that cycle, owner's load=ramload, next state IDLE.
REQ-027 ramstate FREE or BUSY in granted state SHALL hold state and keep owner wait=1.
REQ-028 ramstate ERROR SHALL keep owner wait=1 and return to IDLE (retry via re-arbitration).
REQ-029 Owner dropping all its requests while granted SHALL return FSM to IDLE next cycle with no completion.
REQ-030 iwait SHALL equal iREN except the IGRANT&ACCESS cycle; dwait SHALL equal (dREN|dWEN) except the DGRANT&ACCESS cycle.
REQ-031 iload/dload SHALL be 0 outside their completion cycle.
REQ-032 starve_cnt (3 bits) SHALL increment on each data completion with iREN=1, saturating at STARVE_MAX.
REQ-033 starve_cnt SHALL clear on instruction completion or any cycle with iREN=0.
REQ-034 Request changes to the non-owner during a grant SHALL NOT affect RAM outputs.

Reset
REQ-035 RST=1 SHALL immediately force state IDLE, starve_cnt=0, gnt=00, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, independent of CLK.
REQ-036 RST asserted mid-transaction SHALL abandon it with no completion pulse; iwait/dwait follow their requests during reset.
REQ-037 First grant after RST deassert SHALL occur at the first rising edge with RST=0.

Verification
REQ-038 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> gnt=01, iwait low one cycle, iload=0xDEADBEEF.
REQ-039 iREN and dWEN both set at IDLE, daddr=0x100, dstore=0x1234 -> DGRANT first, ramWEN=1, ramstore=0x1234; IGRANT after data completes.
REQ-040 iREN held, dREN re-asserted continuously, ACCESS every 2nd cycle -> exactly 4 data completions then one instruction grant; repeats.
REQ-041 dREN=dWEN=1 -> ramWEN=1, ramREN=0.
REQ-042 DGRANT then ramstate ERROR -> dwait stays 1, FSM IDLE next cycle, re-grant data; dREN dropped mid-grant -> IDLE, no dwait low pulse.
REQ-043 RST pulsed mid-IGRANT (ramstate BUSY) -> outputs zeroed asynchronously, starve_cnt=0, no iwait low pulse; grant resumes on first edge after release.
